mvu_pe_stream: RTL



---
 rtl/mvu_pe_stream_pkg.sv | 23 ++
 rtl/mvu_pe_stream_tree.sv | 29 ++
 rtl/mvu_pe_stream.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mvu_pe_stream_pkg.sv
// Shared definitions for the streaming MVU processing element: multiply modes
// and width helpers used to size the product and lane-sum datapaths.
package mvau_defn;

    typedef enum logic [1:0] {
        MODE_STD  = 2'd0,
        MODE_XNOR = 2'd1,
        MODE_BIN  = 2'd2
    } mvu_mode_t;

    function automatic int prod_width(input mvu_mode_t mode, input int tsrc, input int twgt);
        case (mode)
            MODE_XNOR: return 1;
            MODE_BIN:  return tsrc + 1;
            default:   return tsrc + twgt;
        endcase
    endfunction

    function automatic int sum_width(input int tp, input int simd);
        return tp + $clog2(simd);
    endfunction

endpackage

// File: rtl/mvu_pe_stream_tree.sv
// Combinational lane-sum adder tree; lanes are sign- or zero-extended to the
// output width before a pairwise reduction.
module mvu_pe_stream_tree #(
    parameter int LANES     = 2,
    parameter int W_IN      = 8,
    parameter int W_OUT     = 9,
    parameter bit IS_SIGNED = 1'b1
) (
    input  logic [LANES*W_IN-1:0] lanes,
    output logic [W_OUT-1:0]      sum
);

    logic [W_OUT-1:0] node [LANES];

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            if (IS_SIGNED) node[i] = W_OUT'($signed(lanes[i*W_IN +: W_IN]));
            else           node[i] = W_OUT'(lanes[i*W_IN +: W_IN]);
        end
        // In-place pairwise reduction: node[0] ends up holding the total.
        for (int unsigned step = 1; step < LANES; step = step * 2) begin
            for (int unsigned i = 0; i + step < LANES; i = i + 2 * step) begin
                node[i] = node[i] + node[i+step];
            end
        end
        sum = node[0];
    end

endmodule

// File: rtl/mvu_pe_stream.sv
// Streaming MVU processing element: SIMD multiply, adder tree, SF-beat fold
// accumulation with valid/ready output. Define MVU_PE_SAT_EN for saturation.
module mvu_pe_stream
    import mvau_defn::*;
#(
    parameter int SIMD     = 2,
    parameter int TSrcI    = 4,
    parameter int TWeightI = 4,
    parameter int TDstI    = 16,
    parameter int SF       = 3,
    parameter int MODE     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_v,
    output logic                     in_rdy,
    input  logic [TSrcI*SIMD-1:0]    in_act,
    input  logic [TWeightI*SIMD-1:0] in_wgt,
    output logic                     out_v,
    input  logic                     out_rdy,
    output logic [TDstI-1:0]         out
);

    localparam mvu_mode_t M  = mvu_mode_t'(MODE);
    localparam int        TP = prod_width(M, TSrcI, TWeightI);
    localparam int        SW = sum_width(TP, SIMD);
    localparam int        AW = ((TDstI > SW) ? TDstI : SW) + 1;
    localparam int        CW = (SF > 1) ? $clog2(SF) : 1;
    localparam bit        SGN = (M != MODE_XNOR);

`ifdef MVU_PE_SAT_EN
    localparam logic signed [AW-1:0] S_MAX = {{(AW-TDstI+1){1'b0}}, {(TDstI-1){1'b1}}};
    localparam logic signed [AW-1:0] S_MIN = {{(AW-TDstI+1){1'b1}}, {(TDstI-1){1'b0}}};
    localparam logic signed [AW-1:0] U_MAX = {{(AW-TDstI){1'b0}}, {TDstI{1'b1}}};
`endif

    logic                   stall;
    logic                   p_v;
    logic [SIMD*TP-1:0]     prod_c;
    logic [SIMD*TP-1:0]     prod_q;
    logic [SW-1:0]          sum;
    logic [TDstI-1:0]       acc;
    logic [CW-1:0]          sf_cnt;
    logic                   last;
    logic signed [AW-1:0]   acc_ext;
    logic signed [AW-1:0]   sum_ext;
    logic signed [AW-1:0]   acc_full;
    logic [TDstI-1:0]       acc_next;

    assign stall  = out_v & ~out_rdy;
    assign in_rdy = ~stall;

    for (genvar i = 0; i < SIMD; i++) begin : g_lane
        logic [TSrcI-1:0]    a;
        logic [TWeightI-1:0] w;
        assign a = in_act[i*TSrcI +: TSrcI];
        assign w = in_wgt[i*TWeightI +: TWeightI];
        if (M == MODE_XNOR) begin : g_xnor
            assign prod_c[i*TP +: TP] = ~(a ^ w);
        end else if (M == MODE_BIN) begin : g_bin
            logic signed [TP-1:0] ae;
            assign ae = TP'($signed(a));
            assign prod_c[i*TP +: TP] = w[0] ? ae : -ae;
        end else begin : g_std
            logic signed [TP-1:0] ae;
            logic signed [TP-1:0] we;
            assign ae = TP'($signed(a));
            assign we = TP'($signed(w));
            assign prod_c[i*TP +: TP] = ae * we;
        end
    end

    mvu_pe_stream_tree #(
        .LANES    (SIMD),
        .W_IN     (TP),
        .W_OUT    (SW),
        .IS_SIGNED(SGN)
    ) u_tree (
        .lanes(prod_q),
        .sum  (sum)
    );

    always_comb begin
        last = (sf_cnt == CW'(SF - 1));
        if (SGN) begin
            sum_ext = AW'($signed(sum));
            acc_ext = AW'($signed(acc));
        end else begin
            sum_ext = AW'(sum);
            acc_ext = AW'(acc);
        end
        if (sf_cnt == '0) acc_ext = '0;
        acc_full = acc_ext + sum_ext;
`ifdef MVU_PE_SAT_EN
        // XNOR sums are non-negative, so that mode clamps with an unsigned compare.
        if (SGN) begin
            if (acc_full > S_MAX)      acc_full = S_MAX;
            else if (acc_full < S_MIN) acc_full = S_MIN;
        end else if ($unsigned(acc_full) > $unsigned(U_MAX)) begin
            acc_full = U_MAX;
        end
`endif
        acc_next = acc_full[TDstI-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_v    <= 1'b0;
            prod_q <= '0;
            acc    <= '0;
            sf_cnt <= '0;
            out    <= '0;
            out_v  <= 1'b0;
        end else if (!stall) begin
            p_v <= in_v;
            if (in_v) prod_q <= prod_c;
            if (p_v) begin
                if (last) begin
                    out    <= acc_next;
                    sf_cnt <= '0;
                end else begin
                    acc    <= acc_next;
                    sf_cnt <= sf_cnt + CW'(1);
                end
            end
            out_v <= p_v & last;
        end
    end

endmodule
